dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = CPU MEM stage
//  (load/store), port 1 = DMA/debug loader. Round-robin arbitration, one access in

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// The arbiter takes the slave view; the requesters and the memory model take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        Req;
    logic [1:0]        Write;
    logic [ADDR_W-1:0] Addr0;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] WData0;
    logic [DATA_W-1:0] WData1;
    logic [1:0]        Gnt;
    logic [1:0]        Done;
    logic [DATA_W-1:0] RData;
    logic              Err;
    logic              CpuStall;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWritedata;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemReaddata;

    modport slave (
        input  Req, Write, Addr0, Addr1, WData0, WData1, MemReaddata,
        output Gnt, Done, RData, Err, CpuStall, MemAddress, MemWritedata, MemRead, MemWrite
    );

    modport master (
        output Req, Write, Addr0, Addr1, WData0, WData1, MemReaddata,
        input  Gnt, Done, RData, Err, CpuStall, MemAddress, MemWritedata, MemRead, MemWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between CPU (port 0) and DMA (port 1).
// One access in flight: Gnt in IDLE, LAT strobe cycles, Done pulse; LAT+2 cycles per access.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65,
    parameter int LAT    = 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [2:0]        LAT_C   = 3'(LAT);

    state_t            state;
    logic              ptr;
    logic              port_l;
    logic              write_l;
    logic [2:0]        cnt;
    logic [1:0]        done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;

    logic              win;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Contention goes to the pointer's port; a lone requester always wins.
    always_comb begin
        win = (bus.Req == 2'b11) ? ptr : bus.Req[1];
        gnt = 2'b00;
        if (state == IDLE && !reset && bus.Req != 2'b00) begin
            gnt = win ? 2'b10 : 2'b01;
        end
        sel_addr  = win ? bus.Addr1  : bus.Addr0;
        sel_wdata = win ? bus.WData1 : bus.WData0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            port_l      <= 1'b0;
            write_l     <= 1'b0;
            cnt         <= 3'd0;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req != 2'b00) begin
                        port_l  <= win;
                        write_l <= bus.Write[win];
                        ptr     <= ~win;
                        if (sel_addr >= DEPTH_A) begin
                            // Out-of-range: skip the memory entirely.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            done_q  <= win ? 2'b10 : 2'b01;
                            state   <= DONE;
                        end else begin
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            mem_read_q  <= ~bus.Write[win];
                            mem_write_q <= bus.Write[win];
                            cnt         <= LAT_C;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 3'd1) begin
                        rdata_q     <= write_l ? '0 : bus.MemReaddata;
                        err_q       <= 1'b0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        done_q      <= port_l ? 2'b10 : 2'b01;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    done_q <= 2'b00;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Gnt          = gnt;
    assign bus.Done         = done_q;
    assign bus.RData        = rdata_q;
    assign bus.Err          = err_q;
    assign bus.CpuStall     = bus.Req[0] & ~done_q[0];
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWritedata = mem_wdata_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LAT=1 instance with an edge-triggered memory model,
// plus a LAT=3 instance for the reset-during-access case.
module tb_dmem_arbiter;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(65), .LAT(LAT1)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(65), .LAT(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(bus3.slave));

    // Memory model: written on the rising edge of MemWrite, read combinationally.
    logic [31:0] mem [0:64];
    logic        mw_prev;
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 65; i++) mem[i] <= 32'(i) + 32'd1000;
            mem[1]  <= 32'd32;
            mem[2]  <= 32'd40;
            mem[3]  <= 32'd47;
            mw_prev <= 1'b0;
        end else begin
            mw_prev <= bus1.MemWrite;
            if (bus1.MemWrite && !mw_prev && bus1.MemAddress < 32'd65)
                mem[bus1.MemAddress[6:0]] <= bus1.MemWritedata;
        end
    end
    assign bus1.MemReaddata = (bus1.MemAddress < 32'd65) ? mem[bus1.MemAddress[6:0]] : 32'hBAD0BAD0;
    assign bus3.MemReaddata = 32'h0000_1234;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut1();
        @(negedge clk);
        rst1 = 1'b1;
        bus1.Req = 2'b00;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
    endtask

    // Bounded wait for any Done pulse on bus1; sampling at negedge+2.
    task automatic wait_done1(output int n);
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (bus1.Done == 2'b00 && n < 10);
    endtask

    task automatic txn(input logic port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input string name);
        int n;
        int strobes;
        logic bad;
        @(negedge clk);
        bus1.Write[port] = wr;
        if (port == 1'b0) begin
            bus1.Addr0 = addr; bus1.WData0 = wd;
        end else begin
            bus1.Addr1 = addr; bus1.WData1 = wd;
        end
        bus1.Req[port] = 1'b1;
        #2;
        check({name, ":gnt"}, 64'(bus1.Gnt), port ? 64'd2 : 64'd1);
        n = 0; strobes = 0; bad = 1'b0;
        do begin
            @(negedge clk); #2; n++;
            if (bus1.MemRead || bus1.MemWrite) begin
                strobes++;
                if (bus1.MemWrite !== wr || bus1.MemRead !== ~wr || bus1.MemAddress !== addr)
                    bad = 1'b1;
            end
        end while (bus1.Done == 2'b00 && n < 10);
        check({name, ":done"},    64'(bus1.Done), port ? 64'd2 : 64'd1);
        check({name, ":latency"}, 64'(n), exp_err ? 64'd1 : 64'(LAT1 + 1));
        check({name, ":rdata"},   64'(bus1.RData), 64'(exp_rd));
        check({name, ":err"},     64'(bus1.Err), 64'(exp_err));
        check({name, ":strobes"}, 64'(strobes), exp_err ? 64'd0 : 64'(LAT1));
        check({name, ":strobe_ok"}, 64'(bad), 64'd0);
        bus1.Req[port] = 1'b0;
    endtask

    initial begin
        int n;
        int viol;
        int grants [$];
        logic [5:0] exp_bits;
        int ph;

        vecs[0] = '{1'b0, 1'b0, 32'd3,          32'd0,          32'd47,         1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd17,         32'd99,         32'd0,          1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'd17,         32'd0,          32'd99,         1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'd100,        32'd0,          32'd0,          1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'd64,         32'h55,         32'd0,          1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'd64,         32'd0,          32'h55,         1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'd65,         32'd0,          32'd0,          1'b1};
        vecs[7] = '{1'b1, 1'b1, 32'h8000_0001,  32'h77,         32'd0,          1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'd0,          32'hDEADBEEF,   32'd0,          1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'd0,          32'd0,          32'hDEADBEEF,   1'b0};

        rst1 = 1'b1; rst3 = 1'b1;
        bus1.Req = 2'b00; bus1.Write = 2'b00; bus1.Addr0 = '0; bus1.Addr1 = '0;
        bus1.WData0 = '0; bus1.WData1 = '0;
        bus3.Req = 2'b00; bus3.Write = 2'b00; bus3.Addr0 = '0; bus3.Addr1 = '0;
        bus3.WData0 = '0; bus3.WData1 = '0;
        repeat (3) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        #2;

        check("reset:ctrl", 64'({bus1.Gnt, bus1.Done, bus1.Err, bus1.MemRead, bus1.MemWrite, bus1.CpuStall}), 64'd0);
        check("reset:rdata", 64'(bus1.RData), 64'd0);
        check("reset:memaddr", 64'({bus1.MemAddress, bus1.MemWritedata}), 64'd0);

        for (int i = 0; i < 10; i++)
            txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));

        // Simultaneous requests straight out of reset, then both held.
        reset_dut1();
        @(negedge clk);
        bus1.Write = 2'b00; bus1.Addr0 = 32'd1; bus1.Addr1 = 32'd2; bus1.Req = 2'b11;
        #2;
        check("both:gnt0", 64'(bus1.Gnt), 64'd1);
        wait_done1(n);
        check("both:done0", 64'({bus1.Done, bus1.RData}), {30'd0, 2'b01, 32'd32});
        bus1.Req[0] = 1'b0;
        @(negedge clk); #2;
        check("both:gnt1", 64'(bus1.Gnt), 64'd2);
        wait_done1(n);
        check("both:done1", 64'({bus1.Done, bus1.RData}), {30'd0, 2'b10, 32'd40});
        bus1.Req[0] = 1'b1;
        viol = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); #2;
            if (bus1.Gnt == 2'b01) grants.push_back(0);
            if (bus1.Gnt == 2'b10) grants.push_back(1);
            if ((bus1.Gnt & bus1.Done) != 2'b00 || bus1.Gnt == 2'b11 || bus1.Done == 2'b11) viol++;
        end
        bus1.Req = 2'b00;
        check("alt:count", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("alt:order%0d", k), (k < grants.size()) ? 64'(grants[k]) : 64'hFF, 64'(k % 2));
        check("alt:exclusive", 64'(viol), 64'd0);

        // CPU back-to-back loads: stall pattern and strobe gap.
        reset_dut1();
        @(negedge clk);
        bus1.Write = 2'b00; bus1.Addr0 = 32'd3; bus1.Req = 2'b01;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            ph = c % 3;
            exp_bits = (ph == 0) ? 6'b01_00_0_1 : (ph == 1) ? 6'b00_00_1_1 : 6'b00_01_0_0;
            check($sformatf("b2b:cyc%0d", c), 64'({bus1.Gnt, bus1.Done, bus1.MemRead, bus1.CpuStall}), 64'(exp_bits));
            if (ph == 2) check($sformatf("b2b:rdata%0d", c), 64'(bus1.RData), 64'd47);
        end
        bus1.Req = 2'b00;

        // Reset in the middle of a LAT=3 access.
        @(negedge clk);
        bus3.Write = 2'b00; bus3.Addr0 = 32'd4; bus3.Req = 2'b01;
        #2;
        check("rst:gnt", 64'(bus3.Gnt), 64'd1);
        @(negedge clk); #2;
        check("rst:busy1", 64'(bus3.MemRead), 64'd1);
        @(negedge clk); #2;
        check("rst:busy2", 64'(bus3.MemRead), 64'd1);
        rst3 = 1'b1; bus3.Req = 2'b00;
        @(negedge clk); #2;
        check("rst:strobes", 64'({bus3.MemRead, bus3.MemWrite, bus3.Done}), 64'd0);
        rst3 = 1'b0;
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #2;
            if (bus3.Done != 2'b00 || bus3.MemRead) viol++;
        end
        check("rst:no_done", 64'(viol), 64'd0);
        @(negedge clk);
        bus3.Addr1 = 32'd5; bus3.Req = 2'b11;
        #2;
        check("rst:prio", 64'(bus3.Gnt), 64'd1);
        n = 0;
        do begin
            @(negedge clk); #2; n++;
        end while (bus3.Done == 2'b00 && n < 10);
        check("rst:done", 64'({bus3.Done, bus3.RData}), {30'd0, 2'b01, 32'h1234});
        check("rst:latency", 64'(n), 64'd4);
        bus3.Req = 2'b00;

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
